// File: rtl/u409_cia_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : u409_cia_cycle                                               |
// | Description : CIA bus-cycle responder. Generates the free-running E clock  |
// |               from CLK40, aligns a decoded CIA-space CPU access to E,      |
// |               drives CIA_ENABLE (gates nCIACS0/nCIACS1), and terminates    |
// |               the CPU cycle with a one-clock nTA plus a read-data strobe.  |
// | Ports       : CLK40      in  40 MHz clock, rising edge                     |
// |               RESET      in  asynchronous active-high reset                |
// |               TS         in  transfer start, one clock                     |
// |               CIA_SPACE  in  address decoded as CIA space (with TS)        |
// |               RnW        in  1 = read, 0 = write (with TS)                 |
// |               E          out E clock to the CIAs                           |
// |               CIA_ENABLE out chip-select gate to the address decoder       |
// |               nTA        out transfer acknowledge, active low              |
// |               RD_LATCH   out one-clock read-data capture strobe            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module u409_cia_cycle #(
   parameter int E_LOW    = 34,
   parameter int E_HIGH   = 22,
   parameter int CS_SETUP = 8
) (
   input  logic CLK40,
   input  logic RESET,
   input  logic TS,
   input  logic CIA_SPACE,
   input  logic RnW,
   output logic E,
   output logic CIA_ENABLE,
   output logic nTA,
   output logic RD_LATCH
);

   localparam int c_P  = E_LOW + E_HIGH;
   localparam int c_CW = $clog2(c_P);

   localparam logic [c_CW-1:0] c_LAST   = c_CW'(c_P - 1);
   localparam logic [c_CW-1:0] c_PENULT = c_CW'(c_P - 2);
   localparam logic [c_CW-1:0] c_E_RISE = c_CW'(E_LOW);
   // Latest counter value at which CIA_ENABLE can still be raised at least
   // CS_SETUP clocks ahead of the coming E rise (strictly below this value).
   localparam logic [c_CW-1:0] c_ACCEPT = c_CW'(E_LOW - CS_SETUP);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_TERM   = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [c_CW-1:0]   r_ecnt;
   logic [c_CW-1:0]   w_ecnt_next;
   logic              r_rnw;
   logic              r_e;
   logic              r_cia_enable;
   logic              r_nta;
   logic              r_rd_latch;
   logic              w_accept;

   assign w_ecnt_next = (r_ecnt == c_LAST) ? '0 : r_ecnt + c_CW'(1);
   assign w_accept    = (r_state == ST_IDLE) && TS && CIA_SPACE;

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = (r_ecnt < c_ACCEPT) ? ST_ACTIVE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Enter ACTIVE exactly as the counter wraps to the start of E low.
            if (r_ecnt == c_LAST) begin
               w_state_next = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (r_ecnt == c_PENULT) begin
               w_state_next = ST_TERM;
            end
         end
         ST_TERM: w_state_next = ST_HOLD;
         ST_HOLD: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State, counter and registered outputs. Outputs are decoded from the
   // next state so each one is a flop output aligned with its state.
   always_ff @(posedge CLK40 or posedge RESET) begin
      if (RESET) begin
         r_state      <= ST_IDLE;
         r_ecnt       <= '0;
         r_rnw        <= 1'b1;
         r_e          <= 1'b0;
         r_cia_enable <= 1'b0;
         r_nta        <= 1'b1;
         r_rd_latch   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ecnt       <= w_ecnt_next;
         r_e          <= (w_ecnt_next >= c_E_RISE);
         r_cia_enable <= (w_state_next != ST_IDLE) && (w_state_next != ST_WAIT);
         r_nta        <= (w_state_next != ST_TERM);
         r_rd_latch   <= (w_state_next == ST_TERM) && r_rnw;
         if (w_accept) begin
            r_rnw <= RnW;
         end
      end
   end

   assign E          = r_e;
   assign CIA_ENABLE = r_cia_enable;
   assign nTA        = r_nta;
   assign RD_LATCH   = r_rd_latch;

endmodule
`default_nettype wire

// File: tb/tb_u409_cia_cycle.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_u409_cia_cycle                                            |
// | Description : Directed self-checking bench for u409_cia_cycle.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_u409_cia_cycle;

   logic CLK40 = 1'b0;
   logic RESET = 1'b1;
   logic TS = 1'b0;
   logic CIA_SPACE = 1'b0;
   logic RnW = 1'b1;
   logic E, CIA_ENABLE, nTA, RD_LATCH;

   int checks = 0;
   int failures = 0;
   int m_cnt = 0;   // reference E-period position, tracks the DUT counter

   u409_cia_cycle dut (
      .CLK40      (CLK40),
      .RESET      (RESET),
      .TS         (TS),
      .CIA_SPACE  (CIA_SPACE),
      .RnW        (RnW),
      .E          (E),
      .CIA_ENABLE (CIA_ENABLE),
      .nTA        (nTA),
      .RD_LATCH   (RD_LATCH)
   );

   always #12.5 CLK40 = ~CLK40;

   always @(posedge CLK40 or posedge RESET) begin
      if (RESET) m_cnt <= 0;
      else       m_cnt <= (m_cnt == 55) ? 0 : m_cnt + 1;
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance (on falling edges) until the reference position equals v.
   task automatic wait_cnt(input int v);
      int n;
      n = 0;
      while (m_cnt != v && n < 120) begin
         @(negedge CLK40);
         n++;
      end
      checks++;
      assert (m_cnt == v) else begin
         failures++;
         $error("FAIL wait_cnt observed=%0d expected=%0d", m_cnt, v);
      end
   endtask

   task automatic idle_ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK40);
         chk($sformatf("%s_E_t%0d", tag, i), E, (m_cnt >= 34));
         chk($sformatf("%s_en_t%0d", tag, i), CIA_ENABLE, 1'b0);
         chk($sformatf("%s_nta_t%0d", tag, i), nTA, 1'b1);
         chk($sformatf("%s_rd_t%0d", tag, i), RD_LATCH, 1'b0);
      end
   endtask

   // Launch one accepted access sampled at counter value k and check every
   // clock until the cycle has returned to idle. With extra=1, CIA-space TS
   // pulses are injected during ACTIVE, TERM and on the HOLD->IDLE edge.
   task automatic do_cycle(input string tag, input int k, input logic rnw, input logic extra);
      int first, term, nta_pulses, rd_pulses;
      wait_cnt(k);
      TS = 1'b1; CIA_SPACE = 1'b1; RnW = rnw;
      @(negedge CLK40);
      TS = 1'b0; CIA_SPACE = 1'b0; RnW = ~rnw;
      if (k < 26) begin first = 1;      term = 55 - k;  end
      else        begin first = 56 - k; term = 111 - k; end
      nta_pulses = 0; rd_pulses = 0;
      for (int t = 1; t <= term + 3; t++) begin
         chk($sformatf("%s_E_t%0d", tag, t), E, (m_cnt >= 34));
         chk($sformatf("%s_en_t%0d", tag, t), CIA_ENABLE, (t >= first && t <= term + 1));
         chk($sformatf("%s_nta_t%0d", tag, t), nTA, (t != term));
         chk($sformatf("%s_rd_t%0d", tag, t), RD_LATCH, (t == term) && rnw);
         if (nTA === 1'b0) nta_pulses++;
         if (RD_LATCH === 1'b1) rd_pulses++;
         if (extra && (t == 10 || t == term || t == term + 1)) begin
            TS = 1'b1; CIA_SPACE = 1'b1;
         end else begin
            TS = 1'b0; CIA_SPACE = 1'b0;
         end
         @(negedge CLK40);
      end
      TS = 1'b0; CIA_SPACE = 1'b0;
      checks++;
      assert (nta_pulses == 1) else begin
         failures++;
         $error("FAIL %s_nta_count observed=%0d expected=1", tag, nta_pulses);
      end
      checks++;
      assert (rd_pulses == (rnw ? 1 : 0)) else begin
         failures++;
         $error("FAIL %s_rd_count observed=%0d expected=%0d", tag, rd_pulses, rnw ? 1 : 0);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge CLK40);
      chk("rst_E", E, 1'b0);
      chk("rst_en", CIA_ENABLE, 1'b0);
      chk("rst_nta", nTA, 1'b1);
      chk("rst_rd", RD_LATCH, 1'b0);
      RESET = 1'b0;

      // E waveform over two full periods after reset release
      idle_ticks("ewave", 112);

      // Read with early acceptance
      do_cycle("rd_k5", 5, 1'b1, 1'b0);
      // Write accepted exactly at the boundary value -> waits one period
      do_cycle("wr_k26", 26, 1'b0, 1'b0);
      // Request during E high -> completes in the next period
      do_cycle("rd_k40", 40, 1'b1, 1'b0);

      // TS outside CIA space is ignored
      wait_cnt(5);
      TS = 1'b1; CIA_SPACE = 1'b0; RnW = 1'b1;
      @(negedge CLK40);
      TS = 1'b0;
      chk("nospace_en0", CIA_ENABLE, 1'b0);
      idle_ticks("nospace", 60);

      // TS pulses in ACTIVE/TERM/HOLD ignored; still one nTA
      do_cycle("extra_k12", 12, 1'b1, 1'b1);
      idle_ticks("post_extra", 60);

      // Reset in ACTIVE at counter 20
      wait_cnt(5);
      TS = 1'b1; CIA_SPACE = 1'b1; RnW = 1'b1;
      @(negedge CLK40);
      TS = 1'b0; CIA_SPACE = 1'b0;
      wait_cnt(20);
      chk("pre_rst_en", CIA_ENABLE, 1'b1);
      #3 RESET = 1'b1;
      #1;
      chk("mid_rst_en", CIA_ENABLE, 1'b0);
      chk("mid_rst_nta", nTA, 1'b1);
      chk("mid_rst_E", E, 1'b0);
      chk("mid_rst_rd", RD_LATCH, 1'b0);
      @(negedge CLK40);
      RESET = 1'b0;
      idle_ticks("after_rst", 60);

      // Fresh access after reset completes normally
      do_cycle("fresh_k10", 10, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
